// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle control unit.
//   state_t        : Moore FSM states of mc_decoder
//   ALU_*          : ALUControl codes
//   RES_*          : ResultSrc mux encodings
//   SRCB_*         : ALUSrcB mux encodings
//   OP_*           : instruction Op field classes
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP   = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b01;
    localparam logic [1:0] OP_BR   = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

endpackage

// File: rtl/mc_decoder_alu_dec.sv
// alu_dec: combinational ALU operation and flag-write decode.
//   active_i        in  1  decode enabled (EXECR/EXECI only)
//   funct_i         in  5  instruction Funct[4:0] (cmd in [4:1], S bit in [0])
//   alu_control_o   out 2  ALU operation code
//   flag_w_o        out 2  [1]=NZ write, [0]=CV write (unconditioned)
module alu_dec
    import ctrl_pkg::*;
(
    input  logic       active_i,
    input  logic [4:0] funct_i,
    output logic [1:0] alu_control_o,
    output logic [1:0] flag_w_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        flag_w_o      = 2'b00;
        if (active_i) begin
            case (funct_i[4:1])
                4'b0100: begin
                    alu_control_o = ALU_ADD;
                    flag_w_o      = {funct_i[0], funct_i[0]};
                end
                4'b0010: begin
                    alu_control_o = ALU_SUB;
                    flag_w_o      = {funct_i[0], funct_i[0]};
                end
                // Logical ops never touch C/V.
                4'b0000: begin
                    alu_control_o = ALU_AND;
                    flag_w_o      = {funct_i[0], 1'b0};
                end
                4'b1100: begin
                    alu_control_o = ALU_ORR;
                    flag_w_o      = {funct_i[0], 1'b0};
                end
                // Unrecognised command: harmless ADD, no flag update.
                default: begin
                    alu_control_o = ALU_ADD;
                    flag_w_o      = 2'b00;
                end
            endcase
        end
    end

endmodule

// File: rtl/mc_decoder.sv
// mc_decoder: multicycle control unit (Moore FSM). Produces the
// unconditioned write strobes consumed by the conditional-logic block plus
// all datapath mux/enable controls. Outputs are combinational from state
// and the instruction fields, which are held stable by the IR.
//   clk, reset       in   clock / synchronous active-low reset
//   Op, Funct, Rd    in   instruction fields [27:26], [25:20], [15:12]
//   PCS, RegW, MemW, FlagW   out  write strobes (forced 0 during reset)
//   NextPC, IRWrite          out  PC increment / IR load enables
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl  out  datapath selects
//   ImmSrc, RegSrc           out  pure functions of Op
//
// Handshake: none. Each strobe is a single-cycle pulse, at most one per
// instruction; downstream samples it on the rising edge it accompanies.
module mc_decoder
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW,
    output logic       NextPC,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc
);

    state_t state_q, state_d;
    state_t out_state;
    logic   alu_active;
    logic   branch;
    logic   reg_w_raw, mem_w_raw, next_pc_raw, ir_write_raw;
    logic [1:0] flag_w_raw;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_MEM:  state_d = MEMADR;
                    OP_DP:   state_d = Funct[5] ? EXECI : EXECR;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    // During reset the selects show their FETCH values, so decode as FETCH
    // and then squash every strobe below.
    assign out_state  = reset ? state_q : FETCH;
    assign alu_active = (out_state == EXECR) || (out_state == EXECI);

    alu_dec u_alu_dec (
        .active_i      (alu_active),
        .funct_i       (Funct[4:0]),
        .alu_control_o (ALUControl),
        .flag_w_o      (flag_w_raw)
    );

    always_comb begin
        reg_w_raw    = 1'b0;
        mem_w_raw    = 1'b0;
        next_pc_raw  = 1'b0;
        ir_write_raw = 1'b0;
        branch       = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_REG;
        case (out_state)
            FETCH: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                ir_write_raw = 1'b1;
                next_pc_raw  = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR:   ALUSrcB = SRCB_IMM;
            MEMREAD:  AdrSrc  = 1'b1;
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_w_raw = 1'b1;
            end
            MEMWB: begin
                ResultSrc = RES_READDATA;
                reg_w_raw = 1'b1;
            end
            EXECR:    ALUSrcB = SRCB_REG;
            EXECI:    ALUSrcB = SRCB_IMM;
            ALUWB:    reg_w_raw = 1'b1;
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign RegW    = reset & reg_w_raw;
    assign MemW    = reset & mem_w_raw;
    assign NextPC  = reset & next_pc_raw;
    assign IRWrite = reset & ir_write_raw;
    assign FlagW   = reset ? flag_w_raw : 2'b00;
    // A register write to R15 is a PC write.
    assign PCS     = reset & ((reg_w_raw & (Rd == 4'hF)) | branch);

    assign ImmSrc  = Op;
    assign RegSrc  = {Op == OP_MEM, Op == OP_BR};

endmodule

// File: tb/tb_mc_decoder.sv
module tb_mc_decoder;

    localparam int W = 19;

    localparam int S_FETCH    = 0;
    localparam int S_DECODE   = 1;
    localparam int S_MEMADR   = 2;
    localparam int S_MEMREAD  = 3;
    localparam int S_MEMWB    = 4;
    localparam int S_MEMWRITE = 5;
    localparam int S_EXECR    = 6;
    localparam int S_EXECI    = 7;
    localparam int S_ALUWB    = 8;
    localparam int S_BRANCH   = 9;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       PCS, RegW, MemW, NextPC, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    mc_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .FlagW      (FlagW),
        .NextPC     (NextPC),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Vector layout: PCS RegW MemW FlagW[2] NextPC IRWrite AdrSrc ResultSrc[2]
    //                ALUSrcA ALUSrcB[2] ALUControl[2] ImmSrc[2] RegSrc[2]
    function automatic logic [W-1:0] dut_vec();
        return {PCS, RegW, MemW, FlagW, NextPC, IRWrite, AdrSrc, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};
    endfunction

    // Reference model written from the per-state output table.
    function automatic logic [W-1:0] model(int st, logic [1:0] op, logic [5:0] f,
                                           logic [3:0] rd, bit in_rst);
        logic pcs, regw, memw, nextpc, irw, adr, srca, br;
        logic [1:0] flagw, res, srcb, aluc, regsrc;
        int s;
        pcs = 0; regw = 0; memw = 0; nextpc = 0; irw = 0; adr = 0; srca = 0; br = 0;
        flagw = 2'b00; res = 2'b00; srcb = 2'b00; aluc = 2'b00;
        s = in_rst ? S_FETCH : st;
        case (s)
            S_FETCH:    begin srca = 1; srcb = 2'b10; res = 2'b10; irw = 1; nextpc = 1; end
            S_DECODE:   begin srca = 1; srcb = 2'b10; res = 2'b10; end
            S_MEMADR:   srcb = 2'b01;
            S_MEMREAD:  adr = 1;
            S_MEMWRITE: begin adr = 1; memw = 1; end
            S_MEMWB:    begin res = 2'b01; regw = 1; end
            S_ALUWB:    regw = 1;
            S_BRANCH:   begin srcb = 2'b01; res = 2'b10; br = 1; end
            default: ;
        endcase
        if (s == S_EXECR || s == S_EXECI) begin
            srcb = (s == S_EXECI) ? 2'b01 : 2'b00;
            if (f[4:1] == 4'b0100)      begin aluc = 2'b00; flagw = {f[0], f[0]}; end
            else if (f[4:1] == 4'b0010) begin aluc = 2'b01; flagw = {f[0], f[0]}; end
            else if (f[4:1] == 4'b0000) begin aluc = 2'b10; flagw = {f[0], 1'b0}; end
            else if (f[4:1] == 4'b1100) begin aluc = 2'b11; flagw = {f[0], 1'b0}; end
        end
        pcs = (regw && rd == 4'hF) || br;
        if (in_rst) begin
            pcs = 0; regw = 0; memw = 0; flagw = 2'b00; nextpc = 0; irw = 0;
        end
        regsrc = {op == 2'b01, op == 2'b10};
        return {pcs, regw, memw, flagw, nextpc, irw, adr, res, srca, srcb, aluc, op, regsrc};
    endfunction

    // scoreboard check
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%05h expected=%05h", tag, got, expv);
        end
    endtask

    // Pops the expected entry for this cycle and compares at the negedge.
    task automatic sample_cycle(input string tag);
        logic [W-1:0] e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got=%05h expected=<empty queue>", tag, dut_vec());
        end else begin
            e = exp_q.pop_front();
            check(tag, dut_vec(), e);
        end
        @(posedge clk);
        #1;
    endtask

    // driver: one full instruction from FETCH, one check per cycle
    task automatic run_instr(input string name, input logic [1:0] op,
                             input logic [5:0] f, input logic [3:0] rd);
        int seq[$];
        Op = op; Funct = f; Rd = rd;
        seq.push_back(S_FETCH);
        seq.push_back(S_DECODE);
        case (op)
            2'b00: begin
                seq.push_back(f[5] ? S_EXECI : S_EXECR);
                seq.push_back(S_ALUWB);
            end
            2'b01: begin
                seq.push_back(S_MEMADR);
                if (f[0]) begin
                    seq.push_back(S_MEMREAD);
                    seq.push_back(S_MEMWB);
                end else begin
                    seq.push_back(S_MEMWRITE);
                end
            end
            2'b10: seq.push_back(S_BRANCH);
            default: ;
        endcase
        foreach (seq[i]) begin
            exp_q.push_back(model(seq[i], op, f, rd, 1'b0));
            sample_cycle($sformatf("%s_c%0d", name, i + 1));
        end
    endtask

    initial begin
        reset = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;

        // reset held low two cycles: FETCH selects, no strobes
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(model(S_FETCH, Op, Funct, Rd, 1'b1));
            sample_cycle($sformatf("reset_c%0d", i));
        end
        reset = 1'b1;

        run_instr("adds_r3",  2'b00, 6'b001001, 4'd3);
        run_instr("ldr_r15",  2'b01, 6'b011001, 4'hF);
        run_instr("str",      2'b01, 6'b011000, 4'd2);
        run_instr("branch",   2'b10, 6'b000000, 4'd0);
        run_instr("orr",      2'b00, 6'b011000, 4'd5);
        run_instr("op11",     2'b11, 6'b101010, 4'hF);
        run_instr("subs_imm", 2'b00, 6'b100101, 4'hF);
        run_instr("ands",     2'b00, 6'b000001, 4'd1);
        run_instr("bad_cmd",  2'b00, 6'b011111, 4'd7);
        run_instr("adds_r3b", 2'b00, 6'b001001, 4'd3);

        // reset asserted while in EXECR aborts the instruction
        Op = 2'b00; Funct = 6'b001001; Rd = 4'hF;
        exp_q.push_back(model(S_FETCH, Op, Funct, Rd, 1'b0));
        sample_cycle("abort_fetch");
        exp_q.push_back(model(S_DECODE, Op, Funct, Rd, 1'b0));
        sample_cycle("abort_decode");
        reset = 1'b0;
        exp_q.push_back(model(S_EXECR, Op, Funct, Rd, 1'b1));
        sample_cycle("abort_execr_rst");
        reset = 1'b1;
        exp_q.push_back(model(S_FETCH, Op, Funct, Rd, 1'b0));
        sample_cycle("abort_next_fetch");
        exp_q.push_back(model(S_DECODE, Op, Funct, Rd, 1'b0));
        sample_cycle("abort_next_decode");
        // finish that restarted instruction cleanly
        exp_q.push_back(model(S_EXECR, Op, Funct, Rd, 1'b0));
        sample_cycle("abort_next_execr");
        exp_q.push_back(model(S_ALUWB, Op, Funct, Rd, 1'b0));
        sample_cycle("abort_next_aluwb");

        // random instruction mix
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            logic [5:0] f;
            logic [3:0] rd;
            op = 2'($urandom_range(0, 3));
            f  = 6'($urandom_range(0, 63));
            rd = 4'($urandom_range(0, 15));
            run_instr($sformatf("rnd%0d", n), op, f, rd);
        end

        // back in FETCH after the last instruction
        exp_q.push_back(model(S_FETCH, Op, Funct, Rd, 1'b0));
        sample_cycle("final_fetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
